// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider.
//
// Contents:
//   DefaultWidth - default width of the ratio field
//   DefaultRatio - default divide ratio loaded at reset
//   state_e      - controller state encoding
//   ratio_ok()   - true when a ratio is usable (non-zero)

package clk_div_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultRatio = 4;

  typedef enum logic [1:0] {
    ST_IDLE,   // stopped, clk_out held low, ratio writable directly
    ST_RUN,    // dividing, no change pending
    ST_PEND,   // dividing, new ratio waits for the end of the period
    ST_DRAIN   // stop requested, finishing the current period
  } state_e;

  // A zero ratio would never wrap the counter, so it is rejected.
  function automatic logic ratio_ok(input logic [DefaultWidth-1:0] n);
    return n != '0;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divide-by-N datapath: phase counter, output toggle flop and tick strobe.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   run     - count while high; when low the counter and clk_out are cleared
//   ratio   - half-period length in clk cycles (never 0)
//   clk_out - divided clock, registered
//   tick    - registered, high in the cycle clk_out takes its new value
//   fall    - combinational: this edge drives clk_out 1->0 (end of a period)
//   wrap    - combinational: the counter is on the last cycle of a phase

module clk_div_core #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] ratio,
  output logic         clk_out,
  output logic         tick,
  output logic         fall,
  output logic         wrap
);

  logic [W-1:0] cnt_q;

  assign wrap = (cnt_q == ratio - W'(1));
  assign fall = run && wrap && clk_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      // Only reached with clk_out already low, so this never makes a pulse.
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the divide-by-N clock generator.
// Accepts new ratios over a valid/ready handshake and applies them only at the
// end of a full output period; starts and stops the divided clock cleanly.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - run request, level sensitive
//   cfg_valid - new ratio offered
//   cfg_n     - offered ratio (clk_out toggles every cfg_n clk cycles)
//   cfg_ready - controller can accept a ratio this cycle
//   clk_out   - divided clock, registered
//   tick      - one-cycle pulse in the cycle clk_out changes
//   busy      - ratio change pending or stop draining
//   err       - one-cycle pulse after an accepted zero ratio

module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned W     = DefaultWidth,
  parameter int unsigned DEF_N = DefaultRatio
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_n,
  output logic         cfg_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic         err
);

  state_e       state_q;
  logic [W-1:0] ratio_q;
  logic [W-1:0] pend_n_q;
  logic         pend_q;

  logic accept;
  logic cfg_zero;
  logic run;
  logic fall;
  logic wrap;
  logic drain_low_done;

  assign accept   = cfg_valid && cfg_ready;
  assign cfg_zero = (cfg_n == '0);

  // Stopping while clk_out is low: the low phase ends without a rise.
  assign drain_low_done = (state_q == ST_DRAIN) && !clk_out && wrap;
  assign run            = (state_q != ST_IDLE) && !drain_low_done;

  assign cfg_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !pend_q;
  assign busy      = (state_q == ST_PEND) || (state_q == ST_DRAIN);

  clk_div_core #(
    .W (W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .ratio   (ratio_q),
    .clk_out (clk_out),
    .tick    (tick),
    .fall    (fall),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ratio_q  <= W'(DEF_N);
      pend_n_q <= '0;
      pend_q   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept && cfg_zero;
      unique case (state_q)
        ST_IDLE: begin
          // Nothing is running, so a new ratio can be used right away.
          if (accept && !cfg_zero) ratio_q <= cfg_n;
          if (en) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // A handshake wins over a simultaneous en fall; the change rides
          // along into DRAIN.
          if (accept && !cfg_zero) begin
            pend_n_q <= cfg_n;
            pend_q   <= 1'b1;
            state_q  <= en ? ST_PEND : ST_DRAIN;
          end else if (!en) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_PEND: begin
          if (fall) begin
            ratio_q <= pend_n_q;
            pend_q  <= 1'b0;
            state_q <= en ? ST_RUN : ST_DRAIN;
          end else if (!en) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fall || drain_low_done) begin
            if (pend_q) ratio_q <= pend_n_q;
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int unsigned W     = 8;
  localparam int unsigned DEF_N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_n;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .W     (W),
    .DEF_N (DEF_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_n     (cfg_n),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
  );

  // Reference model: phase-level view of the divider. A phase lasts m_ratio
  // cycles; m_left counts the cycles still to go in the current phase.
  int m_ratio, m_pend_n, m_left;
  bit m_active, m_stop, m_pend, m_level, m_tick, m_err;
  bit prev_clk;

  function automatic bit m_ready();
    return !m_active || (!m_stop && !m_pend);
  endfunction

  function automatic bit m_busy();
    return m_active && (m_stop || m_pend);
  endfunction

  task automatic model_reset();
    m_ratio  = DEF_N;
    m_pend_n = 0;
    m_left   = 0;
    m_active = 0;
    m_stop   = 0;
    m_pend   = 0;
    m_level  = 0;
    m_tick   = 0;
    m_err    = 0;
    prev_clk = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int n);
    bit acc, was_active, was_stop;
    acc        = v && m_ready();
    was_active = m_active;
    was_stop   = m_stop;
    m_tick     = 0;
    m_err      = acc && (n == 0);
    if (was_active) begin
      if (m_left > 1) begin
        m_left--;
      end else if (m_level) begin
        // end of a full period
        m_level = 0;
        m_tick  = 1;
        if (m_pend) begin
          m_ratio = m_pend_n;
          m_pend  = 0;
        end
        if (was_stop) m_active = 0;
        else m_left = m_ratio;
      end else if (was_stop) begin
        m_active = 0;
        if (m_pend) begin
          m_ratio = m_pend_n;
          m_pend  = 0;
        end
      end else begin
        m_level = 1;
        m_tick  = 1;
        m_left  = m_ratio;
      end
      if (!was_stop && !e) m_stop = 1;
      if (acc && n != 0) begin
        m_pend   = 1;
        m_pend_n = n;
      end
    end else begin
      if (acc && n != 0) m_ratio = n;
      if (e) begin
        m_active = 1;
        m_stop   = 0;
        m_level  = 0;
        m_left   = m_ratio;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic check_model();
    chk("clk_out", int'(clk_out), int'(m_level));
    chk("tick", int'(tick), int'(m_tick));
    chk("busy", int'(busy), int'(m_busy()));
    chk("cfg_ready", int'(cfg_ready), int'(m_ready()));
    chk("err", int'(err), int'(m_err));
    if (clk_out != prev_clk) chk("toggle_without_tick", int'(tick), 1);
    prev_clk = clk_out;
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check.
  task automatic drive_edge(input bit e, input bit v, input int n);
    en        = e;
    cfg_valid = v;
    cfg_n     = W'(n);
    @(posedge clk);
    model_step(e, v, n);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_n     = '0;
    model_reset();
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From idle: start, check first-rise latency and both half-periods, stop.
  task automatic measure(input string tag, input int exp_n);
    int k, h, l;
    bit ok;
    k  = 0;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      drive_edge(1, 0, 0);
      k++;
      if (clk_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout({tag, "_start"});
    else chk({tag, "_start_latency"}, k, exp_n + 1);
    h = 1;
    for (int i = 0; i < 600; i++) begin
      drive_edge(1, 0, 0);
      if (!clk_out) break;
      h++;
    end
    chk({tag, "_high_cycles"}, h, exp_n);
    l = 1;
    for (int i = 0; i < 600; i++) begin
      drive_edge(1, 0, 0);
      if (clk_out) break;
      l++;
    end
    chk({tag, "_low_cycles"}, l, exp_n);
    ok = 0;
    for (int i = 0; i < 1200; i++) begin
      drive_edge(0, 0, 0);
      if (!busy && !clk_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout({tag, "_stop"});
  endtask

  typedef struct {
    bit         en;
    bit         v;
    int         n;
    bit         clk_out;
    bit         tick;
    bit         busy;
    bit         rdy;
    bit         err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input bit v, input int n, input bit c, input bit t,
                     input bit b, input bit r, input bit er);
    vec_t x;
    x = '{en: e, v: v, n: n, clk_out: c, tick: t, busy: b, rdy: r, err: er};
    tbl.push_back(x);
  endtask

  initial begin
    int  ticks;
    bit  ok;
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_n     = '0;
    @(negedge clk);
    do_reset();

    // Start at N=4, zero-ratio offer, change to N=2 mid high phase, stop.
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1, 0);
    add(1, 1, 2, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    foreach (tbl[i]) begin
      drive_edge(tbl[i].en, tbl[i].v, tbl[i].n);
      chk($sformatf("vec%0d_clk_out", i), int'(clk_out), int'(tbl[i].clk_out));
      chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].tick));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_ready", i), int'(cfg_ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].err));
    end

    // Drop en mid high phase at N=3: full high phase, fall, then quiet.
    drive_edge(0, 1, 3);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive_edge(1, 0, 0);
      if (clk_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("n3_rise");
    begin
      int hi;
      hi = 1;
      drive_edge(1, 0, 0);
      if (clk_out) hi++;
      for (int i = 0; i < 20 && clk_out; i++) begin
        drive_edge(0, 0, 0);
        if (clk_out) hi++;
      end
      chk("n3_drop_high_cycles", hi, 3);
      chk("n3_drop_idle_busy", int'(busy), 0);
      chk("n3_drop_idle_ready", int'(cfg_ready), 1);
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      drive_edge(0, 0, 0);
      if (tick) ticks++;
    end
    chk("n3_no_ticks_after_stop", ticks, 0);
    chk("n3_held_low", int'(clk_out), 0);

    // en fall and handshake of 5 in the same cycle.
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive_edge(1, 0, 0);
      if (clk_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("n5_rise");
    drive_edge(0, 1, 5);
    chk("n5_drain_busy", int'(busy), 1);
    chk("n5_drain_ready", int'(cfg_ready), 0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      drive_edge(0, 0, 0);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("n5_drain");
    measure("n5", 5);

    // Reset mid period while a change is pending and tick is high.
    drive_edge(1, 0, 0);
    drive_edge(1, 1, 2);
    chk("rstmid_pend_busy", int'(busy), 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      drive_edge(1, 0, 0);
      if (clk_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("rstmid_rise");
    chk("rstmid_pre_tick", int'(tick), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_clk_out", int'(clk_out), 0);
    chk("rstmid_tick", int'(tick), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ready", int'(cfg_ready), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure("post_rst", DEF_N);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_edge($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
